// File: rtl/led_fade_sequencer_pkg.sv
// Shared definitions for the LED fade sequencer and the strip driver:
// level width, default geometry/timing, FSM state codes and a max helper.
package led_fade_sequencer_pkg;

  localparam int LEVEL_W      = 8;
  localparam int DEF_N_BYTES  = 96;      // 32 LEDs x RGB
  localparam int DEF_ADDR_W   = 7;
  localparam int DEF_TICK_DIV = 500000;

  // Sweep FSM state codes, kept as plain constants for legacy tools
  typedef logic [1:0] fade_state_t;
  localparam fade_state_t ST_IDLE  = 2'd0;
  localparam fade_state_t ST_SWEEP = 2'd1;
  localparam fade_state_t ST_DONE  = 2'd2;

  function automatic logic [LEVEL_W-1:0] level_max(input logic [LEVEL_W-1:0] a,
                                                   input logic [LEVEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fade_tick_gen.sv
// Fade tick generator: free-running divider that raises a pending request
// every TICK_DIV clocks while enabled. A tick that lands on an already
// pending request is dropped and flagged through the sticky overrun bit.
module fade_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick_pending,
  output logic overrun
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;
  logic             tick;

  assign tick = enable && (count == LAST_COUNT);

  // Divider: held at zero while disabled, wraps at the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Pending request: a tick wins over a same-cycle clear so it is not lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_pending <= 1'b0;
    end else if (tick) begin
      tick_pending <= 1'b1;
    end else if (clear) begin
      tick_pending <= 1'b0;
    end
  end

  // Sticky overrun: a tick arrived while an unconsumed request was waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick && tick_pending && !clear) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/led_fade_sequencer.sv
// LED level buffer with periodic exponential fade. Each pending tick sweeps
// every entry through the external x0.8 scaler, one byte per clock, while
// the write port (peak-hold or overwrite) and the read port stay live.
module led_fade_sequencer
  import led_fade_sequencer_pkg::*;
#(
  parameter int N_BYTES   = DEF_N_BYTES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int PEAK_HOLD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [LEVEL_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [LEVEL_W-1:0] rd_data,
  output logic [LEVEL_W-1:0] lut_in,
  input  logic [LEVEL_W-1:0] lut_out,
  output logic               busy,
  output logic               sweep_done,
  output logic               overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BYTES - 1);

  logic [LEVEL_W-1:0] level_buf [N_BYTES];
  logic [LEVEL_W-1:0] level_nxt [N_BYTES];
  logic [LEVEL_W-1:0] rd_val;
  fade_state_t        state;
  logic [ADDR_W-1:0]  idx;
  logic               tick_pending;
  logic               clear_pending;
  logic               sweep_we;

  assign sweep_we      = (state == ST_SWEEP);
  assign clear_pending = (state == ST_IDLE) && tick_pending;
  assign busy          = sweep_we;
  assign sweep_done    = (state == ST_DONE);

  fade_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clear        (clear_pending),
    .tick_pending (tick_pending),
    .overrun      (overrun)
  );

  // Scaler operand: the entry under the sweep index, zero outside a sweep
  always_comb begin
    lut_in = '0;
    if (sweep_we) begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (idx == ADDR_W'(i)) begin
          lut_in = level_buf[i];
        end
      end
    end
  end

  // Next buffer contents: sweep write first, then the level write merged on top
  always_comb begin
    for (int i = 0; i < N_BYTES; i++) begin
      level_nxt[i] = level_buf[i];
      if (sweep_we && (idx == ADDR_W'(i))) begin
        level_nxt[i] = lut_out;
      end
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        level_nxt[i] = (PEAK_HOLD != 0) ? level_max(level_nxt[i], wr_data) : wr_data;
      end
    end
  end

  // Level storage, cleared by reset (including mid-sweep)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BYTES; i++) begin
        level_buf[i] <= '0;
      end
    end else begin
      level_buf <= level_nxt;
    end
  end

  // Read mux: out-of-range indices read as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_val = level_buf[i];
      end
    end
  end

  // Registered read port, sees the buffer before this cycle's writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_val;
    end
  end

  // Sweep FSM: IDLE waits for a tick, SWEEP walks every entry, DONE pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick_pending) begin
            state <= ST_SWEEP;
            idx   <= '0;
          end
        end
        ST_SWEEP: begin
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench for led_fade_sequencer with a small geometry (6 entries, tick every
// 4 clocks). The buffer is mirrored as an array of integers; each sweep
// applies floor(x*4/5) to every entry, writes apply max(), reads are
// compared against the mirror.
module tb_led_fade_sequencer;

  localparam int NB = 6;
  localparam int AW = 3;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [7:0]    lut_in;
  logic [7:0]    lut_out;
  logic          busy;
  logic          sweep_done;
  logic          overrun;

  int compare_count = 0;
  int fail_count = 0;
  int model [NB];

  always #5 clk = ~clk;

  // Shared scaler stand-in: floor(x * 0.8)
  assign lut_out = 8'((32'(lut_in) * 4) / 5);

  led_fade_sequencer #(
    .N_BYTES   (NB),
    .ADDR_W    (AW),
    .TICK_DIV  (TD),
    .PEAK_HOLD (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .lut_in     (lut_in),
    .lut_out    (lut_out),
    .busy       (busy),
    .sweep_done (sweep_done),
    .overrun    (overrun)
  );

  function automatic int scale(input int x);
    return (x * 4) / 5;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle level write, driven from a negedge; mirror follows peak-hold rule
  task automatic apply_stimulus(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = 8'(data);
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < NB) model[addr] = imax(model[addr], data);
  endtask

  task automatic read_check(input int addr);
    int expected;
    rd_addr = AW'(addr);
    @(negedge clk);
    expected = 0;
    if (addr < NB) expected = model[addr];
    check_output($sformatf("rd[%0d]", addr), rd_data, expected);
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) read_check(a);
  endtask

  // Trigger one sweep; optionally collide a write with the sweep at c_addr
  task automatic run_sweep(input bit conflict, input int c_addr, input int c_data);
    int waited;
    int k;
    waited = 0;
    enable = 1'b1;
    while (busy !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    enable = 1'b0;
    if (busy !== 1'b1) check_output("busy_rise", busy, 1);
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      if (k < NB) check_output($sformatf("lut_in[%0d]", k), lut_in, model[k]);
      if (conflict && k == c_addr) begin
        wr_en   = 1'b1;
        wr_addr = AW'(c_addr);
        wr_data = 8'(c_data);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    wr_en = 1'b0;
    check_output("busy_len", k, NB);
    check_output("sweep_done_hi", sweep_done, 1);
    @(negedge clk);
    check_output("sweep_done_lo", sweep_done, 0);
    for (int i = 0; i < NB; i++) begin
      if (conflict && i == c_addr) model[i] = imax(scale(model[i]), c_data);
      else model[i] = scale(model[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fade_tbl [4];
    int sweeps;
    int waited;
    fade_tbl = '{80, 64, 51, 40};
    for (int i = 0; i < NB; i++) model[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_rd_data", rd_data, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_sweep_done", sweep_done, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_lut_in", lut_in, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty-buffer sweep
    run_sweep(1'b0, 0, 0);
    check_output("ovr_after_first", overrun, 0);
    read_all();

    // Single entry fading across four sweeps
    apply_stimulus(2, 100);
    for (int s = 0; s < 4; s++) begin
      run_sweep(1'b0, 0, 0);
      rd_addr = AW'(2);
      @(negedge clk);
      check_output($sformatf("fade_step%0d", s), rd_data, fade_tbl[s]);
    end
    read_all();

    // Peak hold
    apply_stimulus(0, 200);
    read_check(0);
    apply_stimulus(0, 150);
    read_check(0);
    check_output("peak_keep", rd_data, 200);
    apply_stimulus(0, 220);
    read_check(0);
    check_output("peak_raise", rd_data, 220);

    // Write colliding with the sweep at index 3
    apply_stimulus(3, 255);
    run_sweep(1'b1, 3, 210);
    read_check(3);
    check_output("conflict_hi", rd_data, 210);
    apply_stimulus(3, 255);
    run_sweep(1'b1, 3, 100);
    read_check(3);
    check_output("conflict_lo", rd_data, 204);
    read_all();

    // Randomized writes (including out-of-range) and optional collisions
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(2, 6);
      for (int w = 0; w < n; w++) apply_stimulus($urandom_range(0, 7), $urandom_range(0, 255));
      run_sweep(1'($urandom_range(0, 1)), $urandom_range(0, NB - 1), $urandom_range(0, 255));
      read_all();
    end

    // Tick storm: keep ticking until an overrun, then count the sweeps
    sweeps = 0;
    waited = 0;
    enable = 1'b1;
    while (overrun !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
      if (sweep_done === 1'b1) sweeps++;
    end
    enable = 1'b0;
    check_output("storm_overrun", overrun, 1);
    repeat (30) begin
      @(negedge clk);
      if (sweep_done === 1'b1) sweeps++;
    end
    check_output("storm_sweeps", sweeps, 2);
    check_output("storm_ovr_sticky", overrun, 1);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NB; i++) model[i] = scale(model[i]);
    read_all();

    // Reset in the middle of a sweep
    for (int i = 0; i < NB; i++) apply_stimulus(i, $urandom_range(100, 255));
    rd_addr = AW'(1);
    enable = 1'b1;
    waited = 0;
    while (busy !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    enable = 1'b0;
    check_output("mid_busy", busy, 1);
    repeat (3) @(negedge clk);
    check_output("mid_lut_in", lut_in, model[3]);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_lut_in", lut_in, 0);
    check_output("mid_rst_rd_data", rd_data, 0);
    check_output("mid_rst_sweep_done", sweep_done, 0);
    check_output("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NB; i++) model[i] = 0;
    read_all();
    check_output("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
